// File: rtl/systolic_input_skewer.sv
// Row-to-diagonal skewer feeding a systolic array: lane i is delayed by i beats, and
// NumOfInputs-1 zero drain beats are appended after each matrix.
module systolic_input_skewer #(
  parameter int BitSize     = 8,
  parameter int NumOfInputs = 2
) (
  input  logic                           clk,
  input  logic                           res_n,
  input  logic                           in_valid,
  input  logic                           in_start,
  input  logic                           in_last,
  input  logic [NumOfInputs*BitSize-1:0] in_data,
  output logic                           in_ready,
  input  logic                           ds_ready,
  output logic                           out_valid,
  output logic                           out_start,
  output logic                           out_last,
  output logic [NumOfInputs*BitSize-1:0] out_data,
  output logic                           out_err
);

  localparam int N  = NumOfInputs;
  localparam int W  = BitSize;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ready_en_q;
  logic            accept, row_step, drain_step, step;
  logic            out_valid_q, out_valid_d;
  logic            out_start_q, out_start_d;
  logic            out_last_q, out_last_d;
  logic            out_err_q, out_err_d;
  logic [N*W-1:0]  out_data_q, out_data_d;
  logic [N*W-1:0]  tail_word;
  logic [W-1:0]    lane_in [N];

  // ready_en_q keeps in_ready low while reset is asserted
  assign in_ready   = ready_en_q && ds_ready && (state_q != DRAIN);
  assign accept     = in_valid && in_ready;
  assign row_step   = accept && ((state_q == STREAM) || in_start);
  assign drain_step = ds_ready && (state_q == DRAIN);
  assign step       = row_step || drain_step;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, STREAM: begin
        if (row_step) begin
          if (in_last) begin
            if (N > 1) begin
              state_d = DRAIN;
              cnt_d   = CW'(N - 1);
            end else begin
              state_d = IDLE;
            end
          end else begin
            state_d = STREAM;
          end
        end
      end
      DRAIN: begin
        if (drain_step) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid_d = step;
    out_start_d = row_step && (state_q == IDLE);
    out_last_d  = (drain_step && (cnt_q == CW'(1))) || ((N == 1) && row_step && in_last);
    out_err_d   = accept && (((state_q == IDLE) && !in_start) || ((state_q == STREAM) && in_start));
    out_data_d  = step ? tail_word : out_data_q;
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      // column gi sits in the slice counted from the MSB end
      assign lane_in[gi] = drain_step ? '0 : in_data[(N-1-gi)*W +: W];

      if (gi == 0) begin : g_direct
        assign tail_word[(N-1)*W +: W] = lane_in[0];
      end else begin : g_delay
        logic [W-1:0] dl_q [gi];
        logic [W-1:0] dl_d [gi];

        always_comb begin
          dl_d = dl_q;
          if (step) begin
            dl_d[0] = lane_in[gi];
            for (int j = 1; j < gi; j++) dl_d[j] = dl_q[j-1];
          end
        end

        always_ff @(posedge clk or negedge res_n) begin
          if (!res_n) dl_q <= '{default: '0};
          else        dl_q <= dl_d;
        end

        assign tail_word[(N-1-gi)*W +: W] = dl_q[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ready_en_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_start_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_err_q   <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready_en_q  <= 1'b1;
      out_valid_q <= out_valid_d;
      out_start_q <= out_start_d;
      out_last_q  <= out_last_d;
      out_err_q   <= out_err_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_start = out_start_q;
  assign out_last  = out_last_q;
  assign out_err   = out_err_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_systolic_input_skewer.sv
// Directed bench for systolic_input_skewer with NumOfInputs=4, BitSize=8, element (r,c)=8'h{r,c}.
module tb_systolic_input_skewer;

  logic        clk = 1'b0;
  logic        res_n = 1'b0;
  logic        in_valid = 1'b0, in_start = 1'b0, in_last = 1'b0;
  logic [31:0] in_data = '0;
  logic        ds_ready = 1'b0;
  logic        in_ready, out_valid, out_start, out_last, out_err;
  logic [31:0] out_data;

  systolic_input_skewer #(.BitSize(8), .NumOfInputs(4)) dut (
    .clk(clk), .res_n(res_n),
    .in_valid(in_valid), .in_start(in_start), .in_last(in_last), .in_data(in_data),
    .in_ready(in_ready), .ds_ready(ds_ready),
    .out_valid(out_valid), .out_start(out_start), .out_last(out_last),
    .out_data(out_data), .out_err(out_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Monitor: every valid word with its start/last flags, and a running error-pulse count
  logic [31:0] wq [$];
  bit          sq [$];
  bit          lq [$];
  int          err_cnt = 0;

  always @(negedge clk) begin
    if (res_n) begin
      if (out_valid) begin
        wq.push_back(out_data);
        sq.push_back(out_start);
        lq.push_back(out_last);
      end
      if (out_err) err_cnt++;
    end
  end

  int          base_w, base_e;
  logic [31:0] exp_cur [7];
  logic [31:0] exp_t1  [7];
  logic [31:0] exp_t4  [7];

  function automatic logic [31:0] row_w(input int r);
    return {8'(r*16), 8'(r*16+1), 8'(r*16+2), 8'(r*16+3)};
  endfunction

  task automatic step_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic mark();
    base_w = wq.size();
    base_e = err_cnt;
  endtask

  task automatic send(input logic [31:0] d, input logic s, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_start = s;
    in_last  = l;
    while (!in_ready && n < 50) begin
      step_cycles(1);
      n++;
    end
    if (n >= 50) check("send_ready_timeout", 32'(in_ready), 32'd1);
    step_cycles(1);
    in_valid = 1'b0;
    in_start = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_matrix();
    send(row_w(0), 1'b1, 1'b0);
    send(row_w(1), 1'b0, 1'b0);
    send(row_w(2), 1'b0, 1'b0);
    send(row_w(3), 1'b0, 1'b1);
  endtask

  task automatic check_matrix(input string tag, input int n);
    int got_n;
    got_n = wq.size() - base_w;
    check($sformatf("%s_count", tag), 32'(got_n), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (base_w + i < wq.size()) begin
        check($sformatf("%s_w%0d", tag, i), wq[base_w+i], exp_cur[i]);
        check($sformatf("%s_start%0d", tag, i), 32'(sq[base_w+i]), 32'(i == 0));
        check($sformatf("%s_last%0d", tag, i), 32'(lq[base_w+i]), 32'(i == n-1));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int zeros;
    exp_t1 = '{32'h00000000, 32'h10010000, 32'h20110200, 32'h30211203,
               32'h00312213, 32'h00003223, 32'h00000033};
    exp_t4 = '{32'hAA000000, 32'h00BB0000, 32'h0000CC00, 32'h000000DD,
               32'h0, 32'h0, 32'h0};

    // Reset state
    ds_ready = 1'b1;
    step_cycles(2);
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_start", 32'(out_start), 32'd0);
    check("rst_out_last",  32'(out_last),  32'd0);
    check("rst_out_err",   32'(out_err),   32'd0);
    check("rst_out_data",  out_data,       32'd0);
    #2 res_n = 1'b1;
    step_cycles(2);

    // 1: back-to-back 4-row matrix
    exp_cur = exp_t1;
    mark();
    send_matrix();
    zeros = 0;
    for (int k = 0; k < 4; k++) begin
      if (!in_ready) zeros++;
      step_cycles(1);
    end
    check("t1_ready_low_cycles", 32'(zeros), 32'd3);
    step_cycles(6);
    check_matrix("t1", 7);
    $display("t1 words=%0d", wq.size() - base_w);

    // 2: two bubbles after r1
    mark();
    send(row_w(0), 1'b1, 1'b0);
    send(row_w(1), 1'b0, 1'b0);
    check("t2_valid_r1", 32'(out_valid), 32'd1);
    check("t2_data_r1",  out_data,       exp_t1[1]);
    for (int k = 0; k < 2; k++) begin
      step_cycles(1);
      check($sformatf("t2_bubble_valid%0d", k), 32'(out_valid), 32'd0);
      check($sformatf("t2_bubble_hold%0d", k),  out_data,       exp_t1[1]);
    end
    send(row_w(2), 1'b0, 1'b0);
    send(row_w(3), 1'b0, 1'b1);
    step_cycles(10);
    check_matrix("t2", 7);
    $display("t2 words=%0d", wq.size() - base_w);

    // 3: ds_ready low for 3 cycles mid-drain
    mark();
    send_matrix();
    step_cycles(1);
    check("t3_w4_before_stall", out_data, exp_t1[4]);
    ds_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step_cycles(1);
      check($sformatf("t3_stall_valid%0d", k), 32'(out_valid), 32'd0);
      check($sformatf("t3_stall_hold%0d", k),  out_data,       exp_t1[4]);
    end
    ds_ready = 1'b1;
    step_cycles(10);
    check_matrix("t3", 7);
    $display("t3 words=%0d", wq.size() - base_w);

    // 4: single-row matrix
    exp_cur = exp_t4;
    mark();
    send(32'hAABBCCDD, 1'b1, 1'b1);
    step_cycles(10);
    check_matrix("t4", 4);
    $display("t4 words=%0d", wq.size() - base_w);

    // 5: protocol errors
    mark();
    send(row_w(0), 1'b0, 1'b0);
    check("t5_err_pulse", 32'(out_err),   32'd1);
    check("t5_no_valid",  32'(out_valid), 32'd0);
    step_cycles(1);
    check("t5_err_cleared", 32'(out_err), 32'd0);
    step_cycles(3);
    check("t5_err_count",   32'(err_cnt - base_e),   32'd1);
    check("t5_word_count",  32'(wq.size() - base_w), 32'd0);
    exp_cur = exp_t1;
    mark();
    send(row_w(0), 1'b1, 1'b0);
    send(row_w(1), 1'b1, 1'b0);
    check("t5_stream_err", 32'(out_err), 32'd1);
    send(row_w(2), 1'b0, 1'b0);
    send(row_w(3), 1'b0, 1'b1);
    step_cycles(10);
    check_matrix("t5", 7);
    check("t5_stream_err_count", 32'(err_cnt - base_e), 32'd1);
    $display("t5 words=%0d errs=%0d", wq.size() - base_w, err_cnt - base_e);

    // 6: async reset during STREAM, then a fresh matrix
    send(row_w(0), 1'b1, 1'b0);
    send(row_w(1), 1'b0, 1'b0);
    #2 res_n = 1'b0;
    #1;
    check("t6_rst_valid",    32'(out_valid), 32'd0);
    check("t6_rst_start",    32'(out_start), 32'd0);
    check("t6_rst_data",     out_data,       32'd0);
    check("t6_rst_in_ready", 32'(in_ready),  32'd0);
    step_cycles(2);
    #2 res_n = 1'b1;
    step_cycles(2);
    mark();
    send_matrix();
    step_cycles(10);
    check_matrix("t6", 7);
    $display("t6 words=%0d", wq.size() - base_w);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
